// File: rtl/lib_cmps_from_pow2_if.sv
// Beat-in / vector-out bundle for the one-hot recomposer.
// master: upstream beat source plus downstream vector sink; slave: the recomposer.
interface lib_cmps_from_pow2_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic             onehot_vld;
    logic             onehot_rdy;
    logic [WIDTH-1:0] onehot;
    logic             onehot_last;
    logic             vect_vld;
    logic             vect_rdy;
    logic [WIDTH-1:0] vect;
    logic [CntW-1:0]  cnt;
    logic             err_nonhot;
    logic             err_dup;
    logic             err_ovf;

    modport master (
        output onehot_vld, onehot, onehot_last, vect_rdy,
        input  onehot_rdy, vect_vld, vect, cnt, err_nonhot, err_dup, err_ovf
    );

    modport slave (
        input  onehot_vld, onehot, onehot_last, vect_rdy,
        output onehot_rdy, vect_vld, vect, cnt, err_nonhot, err_dup, err_ovf
    );
endinterface

// File: rtl/lib_cmps_from_pow2.sv
// Streaming recomposer: ORs a frame of zero/one-hot beats into one vector,
// counts the bits set and flags malformed, repeated or excess beats.
module lib_cmps_from_pow2 #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_BEATS = WIDTH
) (
    input logic                 clk,
    input logic                 rstn,
    lib_cmps_from_pow2_if.slave bus
);
    localparam int unsigned CntW  = $clog2(WIDTH + 1);
    localparam int unsigned BeatW = $clog2(MAX_BEATS + 1);
    localparam logic [BeatW-1:0] MaxBeats = BeatW'(MAX_BEATS);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [BeatW-1:0] beats_q, beats_d;
    logic             nonhot_q, nonhot_d;
    logic             dup_q, dup_d;
    logic             ovf_q, ovf_d;

    logic accept;
    logic release_frame;
    logic beat_zero;
    logic beat_multi;
    logic beat_dup;

    assign accept        = (state_q == StAccum) && bus.onehot_vld;
    assign release_frame = (state_q == StHold) && bus.vect_rdy;
    assign beat_zero     = (bus.onehot == '0);
    // x & (x-1) clears the lowest set bit; anything left means more than one bit
    assign beat_multi    = ((bus.onehot & (bus.onehot - WIDTH'(1))) != '0);
    assign beat_dup      = ((bus.onehot & acc_q) != '0);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: close on an accepted last beat, reopen on release
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (accept && bus.onehot_last) state_d = StHold;
            StHold:  if (bus.vect_rdy)              state_d = StAccum;
            default: state_d = StAccum;
        endcase
    end

    // Frame accumulator, counters and sticky flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            beats_q  <= '0;
            nonhot_q <= 1'b0;
            dup_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            beats_q  <= beats_d;
            nonhot_q <= nonhot_d;
            dup_q    <= dup_d;
            ovf_q    <= ovf_d;
        end
    end

    // Beat classification in priority order: overflow, zero, non-hot, duplicate, new bit
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        beats_d  = beats_q;
        nonhot_d = nonhot_q;
        dup_d    = dup_q;
        ovf_d    = ovf_q;
        if (release_frame) begin
            acc_d    = '0;
            cnt_d    = '0;
            beats_d  = '0;
            nonhot_d = 1'b0;
            dup_d    = 1'b0;
            ovf_d    = 1'b0;
        end else if (accept) begin
            if (beats_q == MaxBeats) begin
                // Counter saturates; further beats only keep the flag set
                ovf_d = 1'b1;
            end else begin
                beats_d = beats_q + BeatW'(1);
                if (beat_zero) begin
                    // zero beats are legal padding
                end else if (beat_multi) begin
                    nonhot_d = 1'b1;
                end else if (beat_dup) begin
                    dup_d = 1'b1;
                end else begin
                    acc_d = acc_q | bus.onehot;
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end
    end

    // Outputs: handshakes decoded from state, data straight from registers
    always_comb begin
        bus.onehot_rdy = (state_q == StAccum);
        bus.vect_vld   = (state_q == StHold);
        bus.vect       = acc_q;
        bus.cnt        = cnt_q;
        bus.err_nonhot = nonhot_q;
        bus.err_dup    = dup_q;
        bus.err_ovf    = ovf_q;
    end
endmodule
